// File: rtl/mux_arb_reg.sv
// ---------------------------------------------------------------------------
// mux_arb_reg
//
// Parametrised N-channel, W-bit registered multiplexer with valid/ready
// handshakes on every channel and on the output. A single output register
// gives one cycle of latency. Because a new word can load in the same cycle
// the held word drains, the block sustains one word per cycle.
//
// Two selection modes:
//   mode = 0 : explicit select. Channel `sel` is granted when it is valid.
//   mode = 1 : round-robin. The search starts one past the last channel
//              granted in this mode and wraps modulo CHANNELS.
//
// Parameters:
//   WIDTH    data width per channel in bits (>= 1)
//   CHANNELS number of input channels (>= 2)
//   SEL_W    channel-index width, derived from CHANNELS (leave at default)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   mode       0 = explicit select, 1 = round-robin
//   sel        channel index used when mode = 0
//   in_valid   per-channel request
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept (combinational, at most one bit set)
//   out_valid  output register holds a word
//   out_data   registered selected data
//   out_chan   index of the channel that supplied out_data
//   out_ready  downstream accept
// ---------------------------------------------------------------------------
module mux_arb_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  // The only control state is whether the output register holds a word.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SEL_W-1:0]   chan_q,  chan_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic                load;
  logic [CHANNELS-1:0] sel_grant;
  logic [CHANNELS-1:0] rr_grant;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    grant_data;
  logic                xfer;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

  // The register can accept a word when it is empty or is draining now.
  assign load = !out_valid || out_ready;

  // Explicit select. Each grant bit depends only on its own in_valid bit,
  // and select values at or beyond CHANNELS never match any channel.
  always_comb begin
    sel_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_grant[i] = (sel == SEL_W'(i)) && in_valid[i];
    end
  end

  // Round-robin search from rr_ptr+1 upward with wrap. The last offset
  // tried is CHANNELS itself, which lands back on rr_ptr, so a lone
  // requester that was just served is granted again.
  always_comb begin
    logic found;
    int   idx;
    rr_grant = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= CHANNELS; off++) begin
      idx = (int'(rr_ptr_q) + off) % CHANNELS;
      if (!found && in_valid[idx]) begin
        rr_grant[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign grant = mode ? rr_grant : sel_grant;

  // in_ready is forced low during reset so nothing is accepted while the
  // output register is being cleared.
  assign in_ready = grant & {CHANNELS{load && reset}};
  assign xfer     = |in_ready;

  // One-hot to index and data mux for the granted channel.
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        grant_idx  = SEL_W'(i);
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic. When loading with no grant the register empties but
  // keeps its last data and channel. The round-robin pointer moves only on
  // a mode-1 transfer, so explicit-select traffic does not disturb fairness.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    chan_d   = chan_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      if (xfer) begin
        state_d = FULL;
        data_d  = grant_data;
        chan_d  = grant_idx;
        if (mode) begin
          rr_ptr_d = grant_idx;
        end
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // Output register and arbitration pointer. The pointer resets to the
  // last channel so channel 0 has first priority after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      chan_q   <= '0;
      rr_ptr_q <= SEL_W'(CHANNELS - 1);
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_reg
//
// Directed testbench for mux_arb_reg with WIDTH=32, CHANNELS=4. Inputs are
// driven 1 ns after the rising edge; combinational in_ready is checked 1 ns
// later and registered outputs are checked 1 ns after the following edge.
// ---------------------------------------------------------------------------
module tb_mux_arb_reg;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_1111;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h4444_3333;

  logic                      clk;
  logic                      reset;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_ready;

  int testsRun;
  int testsFailed;

  mux_arb_reg #(
    .WIDTH(WIDTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .sel(sel),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_ready(out_ready)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the control inputs and let combinational logic settle.
  task automatic applyStimulus(input logic m, input logic [SEL_W-1:0] s,
                               input logic [CHANNELS-1:0] v, input logic ordy);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered output check after an edge.
  task automatic checkRegs(input string tag, input logic v,
                           input logic [31:0] d, input logic [SEL_W-1:0] c);
    checkOutput({tag, " out_valid"}, 64'(out_valid), 64'(v));
    checkOutput({tag, " out_data"},  64'(out_data),  64'(d));
    checkOutput({tag, " out_chan"},  64'(out_chan),  64'(c));
  endtask

  function automatic logic [31:0] chanData(input int c);
    case (c)
      0:       return D0;
      1:       return D1;
      2:       return D2;
      default: return D3;
    endcase
  endfunction

  initial begin
    int rrSeq [6];
    testsRun    = 0;
    testsFailed = 0;
    rrSeq       = '{0, 1, 2, 3, 0, 1};

    reset     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    in_data   = {D3, D2, D1, D0};

    // Reset state, with a valid request present that must not be accepted.
    tick();
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1);
    checkRegs("reset", 1'b0, 32'h0, 2'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'h0);
    tick();
    reset = 1'b1;

    // Fixed select of channel 2.
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1);
    checkOutput("sel2 in_ready", 64'(in_ready), 64'b0100);
    tick();
    checkRegs("sel2", 1'b1, D2, 2'd2);

    // Round-robin with all channels requesting: 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
      checkOutput($sformatf("rr%0d in_ready", i), 64'(in_ready), 64'(1) << rrSeq[i]);
      tick();
      checkRegs($sformatf("rr%0d", i), 1'b1, chanData(rrSeq[i]), SEL_W'(rrSeq[i]));
    end

    // Backpressure: word from channel 1 held for three cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd0, 4'b0011, 1'b0);
      checkOutput($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'h0);
      tick();
      checkRegs($sformatf("bp%0d", i), 1'b1, D1, 2'd1);
    end
    // Release: pointer at 1, search 2,3,0 lands on channel 0.
    applyStimulus(1'b1, 2'd0, 4'b0011, 1'b1);
    checkOutput("bp release in_ready", 64'(in_ready), 64'b0001);
    tick();
    checkRegs("bp release", 1'b1, D0, 2'd0);

    // Select of an idle channel: no grant, register drains.
    applyStimulus(1'b0, 2'd3, 4'b0111, 1'b1);
    checkOutput("sel3 idle in_ready", 64'(in_ready), 64'h0);
    tick();
    checkRegs("sel3 idle", 1'b0, D0, 2'd0);

    // Round-robin with nothing valid: stays empty, data retained.
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    checkOutput("rr idle in_ready", 64'(in_ready), 64'h0);
    tick();
    checkRegs("rr idle", 1'b0, D0, 2'd0);

    // Load channel 3 (pointer at 0, search 1,2,3), then hold it.
    applyStimulus(1'b1, 2'd0, 4'b1000, 1'b1);
    checkOutput("pre-reset in_ready", 64'(in_ready), 64'b1000);
    tick();
    checkRegs("pre-reset", 1'b1, D3, 2'd3);

    // Asynchronous reset between edges clears the held word immediately.
    applyStimulus(1'b1, 2'd0, 4'b1010, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    checkRegs("async reset", 1'b0, 32'h0, 2'd0);
    checkOutput("async reset in_ready", 64'(in_ready), 64'h0);
    tick();
    reset = 1'b1;

    // After release: pointer at 3, so channel 1 then channel 3.
    applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
    checkOutput("post-reset 1 in_ready", 64'(in_ready), 64'b0010);
    tick();
    checkRegs("post-reset 1", 1'b1, D1, 2'd1);
    applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
    checkOutput("post-reset 2 in_ready", 64'(in_ready), 64'b1000);
    tick();
    checkRegs("post-reset 2", 1'b1, D3, 2'd3);

    // Lone requester on channel 2 is granted every cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd0, 4'b0100, 1'b1);
      checkOutput($sformatf("lone%0d in_ready", i), 64'(in_ready), 64'b0100);
      tick();
      checkRegs($sformatf("lone%0d", i), 1'b1, D2, 2'd2);
    end

    // Switch to explicit select of channel 1: channel 2 is ignored.
    applyStimulus(1'b0, 2'd1, 4'b0110, 1'b1);
    checkOutput("switch sel1 in_ready", 64'(in_ready), 64'b0010);
    tick();
    checkRegs("switch sel1", 1'b1, D1, 2'd1);

    // Pointer must still be 2, so round-robin over all picks channel 3.
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    checkOutput("ptr kept in_ready", 64'(in_ready), 64'b1000);
    tick();
    checkRegs("ptr kept", 1'b1, D3, 2'd3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
